central_register_bank: RTL

- Receiving end of the service-gate interface.
- Holds the central registers A, L, Q, Z, B and G.
- Consumes the clear gates (active-high), write gates (active-low) and read gates (active-low) produced by the service-gate logic.
- Loads registers from the write bus and drives the selected register contents back onto the read bus, so that the register-transfer sequencing of each control pulse takes effect in register state.

---
 rtl/central_register_bank_pkg.sv | 23 ++
 rtl/central_register_bank_cell.sv | 22 ++
 rtl/central_register_bank.sv | 111 +++++++++++
 3 files changed

// File: rtl/central_register_bank_pkg.sv
// rtl/central_register_bank_pkg.sv - shared widths, bit positions and cycle helpers
package central_register_bank_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] Z_RESET_DEFAULT = 16'o04000;

    // Bit positions use hardware numbering (bit 16 = MSB); subtract 1 for indices.
    localparam int SGN         = 16;
    localparam int OVF         = 15;
    localparam int EDOP_SRC_HI = 14;
    localparam int EDOP_SRC_LO = 8;
    localparam int EDOP_DST_HI = 7;
    localparam int EDOP_DST_LO = 1;

    function automatic logic [WIDTH-1:0] cyl16(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], w[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] cyr16(input logic [WIDTH-1:0] w);
        return {w[0], w[WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/central_register_bank_cell.sv
// rtl/central_register_bank_cell.sv - register with clear-then-OR load rule
module central_reg_cell #(
    parameter int             W         = 16,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         wr,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= RESET_VAL;
        end else begin
            q <= (clr ? '0 : q) | (wr ? din : '0);
        end
    end

endmodule

// File: rtl/central_register_bank.sv
// rtl/central_register_bank.sv - central registers A, L, Q, Z, B, G with gated read/write buses
module central_register_bank
    import central_register_bank_pkg::*;
#(
    parameter int               WIDTH_P = WIDTH,
    parameter logic [WIDTH-1:0] Z_RESET = Z_RESET_DEFAULT
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST,
    input  logic [WIDTH_P-1:0] WL_n,
    input  logic               CAG,
    input  logic               CLG1G,
    input  logic               CLG2G,
    input  logic               CQG,
    input  logic               CZG,
    input  logic               CBG,
    input  logic               CGG,
    input  logic               WAG_n,
    input  logic               WLG_n,
    input  logic               WQG_n,
    input  logic               WZG_n,
    input  logic               WBG_n,
    input  logic               WG1G_n,
    input  logic               WG3G_n,
    input  logic               WG5G_n,
    input  logic               WEDOPG_n,
    input  logic               RAG_n,
    input  logic               RLG_n,
    input  logic               RQG_n,
    input  logic               RZG_n,
    input  logic               RGG_n,
    input  logic               RBHG_n,
    input  logic               RBLG_n,
    input  logic               RCG_n,
    output logic [WIDTH_P-1:0] RL_n,
    output logic [11:0]        Z_OUT,
    output logic               OVF_n,
    output logic               A15_n,
    output logic               A16_n
);

    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] a, l, q, z, b, g;
    logic [WIDTH-1:0] g_din;
    logic             g_wr;
    logic [WIDTH-1:0] rd;

    assign w = ~WL_n;

    // G write gates wire-OR their transformed bus terms.
    always_comb begin
        g_din = '0;
        if (!WG1G_n) g_din = g_din | w;
        if (!WG3G_n) g_din = g_din | cyl16(w);
        if (!WG5G_n) g_din = g_din | cyr16(w);
        if (!WEDOPG_n) begin
            g_din[EDOP_DST_HI-1:EDOP_DST_LO-1] = g_din[EDOP_DST_HI-1:EDOP_DST_LO-1]
                                               | w[EDOP_SRC_HI-1:EDOP_SRC_LO-1];
        end
    end

    assign g_wr = !WG1G_n || !WG3G_n || !WG5G_n || !WEDOPG_n;

    central_reg_cell #(.W(WIDTH)) u_a (
        .clk(SIM_CLK), .resetn(SIM_RST), .clr(CAG), .wr(!WAG_n), .din(w), .q(a)
    );

    // L clears in two independent fields: L[14:1] and L[16:15].
    central_reg_cell #(.W(14)) u_l_lo (
        .clk(SIM_CLK), .resetn(SIM_RST), .clr(CLG1G), .wr(!WLG_n), .din(w[13:0]), .q(l[13:0])
    );

    central_reg_cell #(.W(2)) u_l_hi (
        .clk(SIM_CLK), .resetn(SIM_RST), .clr(CLG2G), .wr(!WLG_n), .din(w[15:14]), .q(l[15:14])
    );

    central_reg_cell #(.W(WIDTH)) u_q (
        .clk(SIM_CLK), .resetn(SIM_RST), .clr(CQG), .wr(!WQG_n), .din(w), .q(q)
    );

    central_reg_cell #(.W(WIDTH), .RESET_VAL(Z_RESET)) u_z (
        .clk(SIM_CLK), .resetn(SIM_RST), .clr(CZG), .wr(!WZG_n), .din(w), .q(z)
    );

    central_reg_cell #(.W(WIDTH)) u_b (
        .clk(SIM_CLK), .resetn(SIM_RST), .clr(CBG), .wr(!WBG_n), .din(w), .q(b)
    );

    central_reg_cell #(.W(WIDTH)) u_g (
        .clk(SIM_CLK), .resetn(SIM_RST), .clr(CGG), .wr(g_wr), .din(g_din), .q(g)
    );

    always_comb begin
        rd = '0;
        if (!RAG_n)  rd = rd | a;
        if (!RLG_n)  rd = rd | l;
        if (!RQG_n)  rd = rd | q;
        if (!RZG_n)  rd = rd | z;
        if (!RGG_n)  rd = rd | g;
        if (!RCG_n)  rd = rd | ~b;
        if (!RBHG_n) rd = rd | {b[15:7], 7'b0};
        if (!RBLG_n) rd = rd | {9'b0, b[6:0]};
    end

    assign RL_n  = ~rd;
    assign Z_OUT = z[11:0];
    assign OVF_n = ~(a[SGN-1] ^ a[OVF-1]);
    assign A16_n = ~a[SGN-1];
    assign A15_n = ~a[OVF-1];

endmodule
